// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
// Widths follow $clog2(n+1). The function never returns zero, so a count of 0 still gets a 1-bit port.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  localparam int LOSS_CNT_W = 16;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// PLL-side and downstream-side signals of the lock sequencer. The sequencer drives the master modport.
// Defining PLL_SEQ_LOSS_CNT_EN adds the lock_loss_cnt signal.
interface pll_lock_sequencer_if #(
  parameter int RETRY_W = 2
);

  logic               pll_locked;
  logic               pll_rst;
  logic               sys_rst;
  logic               ready;
  logic               fault;
  logic [RETRY_W-1:0] retry_cnt;
`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [pll_seq_pkg::LOSS_CNT_W-1:0] lock_loss_cnt;
`endif

  modport master (
    input  pll_locked,
`ifdef PLL_SEQ_LOSS_CNT_EN
    output lock_loss_cnt,
`endif
    output pll_rst, sys_rst, ready, fault, retry_cnt
  );

  modport slave (
    output pll_locked,
`ifdef PLL_SEQ_LOSS_CNT_EN
    input  lock_loss_cnt,
`endif
    input  pll_rst, sys_rst, ready, fault, retry_cnt
  );

endinterface

// File: rtl/pll_seq_sync.sv
// Generic two-flop synchronizer into refclk. It adds two cycles of latency and clears to 0 on rst.
module pll_seq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up/supervision FSM. Outputs are registered from next_state; ready rises LOCK_STABLE_CYCLES+2 after lock is sampled.
// Defining PLL_SEQ_LOSS_CNT_EN adds a saturating count of RUN->RESET_PLL lock losses.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                 refclk,
  input  logic                 rst,
  pll_lock_sequencer_if.master bus
);

  localparam int HOLD_W  = cnt_w(RST_HOLD_CYCLES);
  localparam int TMO_W   = cnt_w(LOCK_TIMEOUT_CYCLES);
  localparam int STAB_W  = cnt_w(LOCK_STABLE_CYCLES);
  localparam int RETRY_W = cnt_w(MAX_RETRIES);

  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [STAB_W-1:0]  STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  localparam logic [2:0] ST_RESET_PLL = RESET_PLL;
  localparam logic [2:0] ST_WAIT_LOCK = WAIT_LOCK;
  localparam logic [2:0] ST_STABILIZE = STABILIZE;
  localparam logic [2:0] ST_RUN       = RUN;
  localparam logic [2:0] ST_FAULT     = FAULT;

  logic [2:0]         state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [STAB_W-1:0]  stab_q, stab_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_rst_q, sys_rst_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;
  logic               locked_s;
  logic               tmo_hit;
  logic               expire;

  pll_seq_sync #(.WIDTH(1)) u_sync (
    .refclk   (refclk),
    .rst      (rst),
    .async_in (bus.pll_locked),
    .sync_out (locked_s)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    tmo_d   = '0;
    stab_d  = '0;
    retry_d = retry_q;
    expire  = 1'b0;
    tmo_hit = (tmo_q == TMO_LAST);

    case (state_q)
      ST_RESET_PLL: begin
        if (hold_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
        else                     hold_d  = hold_q + 1'b1;
      end
      ST_WAIT_LOCK: begin
        tmo_d = tmo_hit ? tmo_q : tmo_q + 1'b1;
        if (tmo_hit)       expire  = 1'b1;
        else if (locked_s) state_d = ST_STABILIZE;
      end
      ST_STABILIZE: begin
        // The timeout keeps running across lock chatter, so one attempt is bounded.
        tmo_d = tmo_hit ? tmo_q : tmo_q + 1'b1;
        if (locked_s && (stab_q == STAB_LAST)) state_d = ST_RUN;
        else if (tmo_hit)                      expire  = 1'b1;
        else if (!locked_s)                    state_d = ST_WAIT_LOCK;
        else                                   stab_d  = stab_q + 1'b1;
      end
      ST_RUN: begin
        if (!locked_s) state_d = ST_RESET_PLL;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_RESET_PLL;
    endcase

    if (expire) begin
      if (retry_q == RETRY_MAX) begin
        state_d = ST_FAULT;
      end else begin
        retry_d = retry_q + 1'b1;
        state_d = ST_RESET_PLL;
      end
    end
    if (state_d == ST_RUN) retry_d = '0;

    pll_rst_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fault_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= ST_RESET_PLL;
      hold_q    <= '0;
      tmo_q     <= '0;
      stab_q    <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      tmo_q     <= tmo_d;
      stab_q    <= stab_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst   = sys_rst_q;
  assign bus.ready     = ready_q;
  assign bus.fault     = fault_q;
  assign bus.retry_cnt = retry_q;

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if ((state_q == ST_RUN) && (state_d == ST_RESET_PLL) && (loss_q != '1))
      loss_d = loss_q + 1'b1;
  end

  always_ff @(posedge refclk) begin
    if (rst) loss_q <= '0;
    else     loss_q <= loss_d;
  end

  assign bus.lock_loss_cnt = loss_q;
`endif

endmodule
